// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: signal bundle between the game flow controller and the rest of the game
interface game_flow_ctrl_if;
    logic       enter;
    logic       frame_tick;
    logic       ep_boom;
    logic       boss_boom;
    logic [3:0] present_health;
    logic       enemy_alive;
    logic [1:0] state;
    logic       play_en;
    logic       boss_en;
    logic       end_en;
    logic       win;
    logic       game_rst;
    logic       spawn_enemy;
    logic [9:0] score;

    modport master (
        output enter, frame_tick, ep_boom, boss_boom, present_health, enemy_alive,
        input  state, play_en, boss_en, end_en, win, game_rst, spawn_enemy, score
    );

    modport slave (
        input  enter, frame_tick, ep_boom, boss_boom, present_health, enemy_alive,
        output state, play_en, boss_en, end_en, win, game_rst, spawn_enemy, score
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: start/play/boss/over sequencing, scoring and enemy spawn scheduling
module game_flow_ctrl #(
    parameter int BOSS_SCORE   = 10,
    parameter int SPAWN_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input logic             clk,
    input logic             rst,
    game_flow_ctrl_if.slave gf
);
    localparam int EARLY_FRAMES = 30;
    localparam int SW = $clog2(SPAWN_FRAMES + 1);
    localparam int OW = $clog2(OVER_FRAMES + EARLY_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_BOSS  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        st;
    state_t        nxt;
    logic          enter_s1;
    logic          enter_s2;
    logic          enter_d;
    logic          enter_edge;
    logic          dead;
    logic          start_game;
    logic          over_done;
    logic          spawn_now;
    logic [10:0]   sum1;
    logic [10:0]   sum10;
    logic [9:0]    inc1;
    logic [9:0]    inc10;
    logic [9:0]    nxt_score;
    logic          nxt_win;
    logic [9:0]    score_q;
    logic          win_q;
    logic          play_en_q;
    logic          boss_en_q;
    logic          end_en_q;
    logic          game_rst_q;
    logic          spawn_q;
    logic [SW-1:0] spawn_cnt;
    logic          spawn_pend;
    logic [OW-1:0] over_cnt;

    assign gf.state       = st;
    assign gf.play_en     = play_en_q;
    assign gf.boss_en     = boss_en_q;
    assign gf.end_en      = end_en_q;
    assign gf.win         = win_q;
    assign gf.game_rst    = game_rst_q;
    assign gf.spawn_enemy = spawn_q;
    assign gf.score       = score_q;

    // Next-state, saturating score and spawn decision for the coming edge
    always_comb begin
        enter_edge = enter_s2 & ~enter_d;
        sum1       = {1'b0, score_q} + 11'd1;
        sum10      = {1'b0, score_q} + 11'd10;
        inc1       = sum1[10] ? 10'h3ff : sum1[9:0];
        inc10      = sum10[10] ? 10'h3ff : sum10[9:0];
        dead       = (st == ST_PLAY || st == ST_BOSS) && gf.present_health == 4'd0;
        start_game = st == ST_START && enter_edge;
        over_done  = gf.frame_tick && (over_cnt + OW'(1)) >= OW'(OVER_FRAMES);
        nxt        = st;
        nxt_score  = score_q;
        nxt_win    = win_q;
        case (st)
            ST_START: begin
                if (enter_edge) begin
                    nxt       = ST_PLAY;
                    nxt_score = '0;
                    nxt_win   = 1'b0;
                end
            end
            ST_PLAY: begin
                if (dead) begin
                    nxt     = ST_OVER;
                    nxt_win = 1'b0;
                end else if (gf.ep_boom) begin
                    nxt_score = inc1;
                    nxt       = inc1 >= 10'(BOSS_SCORE) ? ST_BOSS : ST_PLAY;
                end
            end
            ST_BOSS: begin
                if (dead) begin
                    nxt     = ST_OVER;
                    nxt_win = 1'b0;
                end else if (gf.boss_boom) begin
                    nxt       = ST_OVER;
                    nxt_win   = 1'b1;
                    nxt_score = inc10;
                end
            end
            ST_OVER: begin
                if (over_done || (enter_edge && over_cnt >= OW'(EARLY_FRAMES)))
                    nxt = ST_START;
            end
            default: nxt = ST_START;
        endcase
        spawn_now = st == ST_PLAY && nxt == ST_PLAY && !spawn_q && !gf.enemy_alive &&
                    (spawn_pend || (gf.frame_tick && spawn_cnt == SW'(SPAWN_FRAMES - 1)));
    end

    // Two-flop enter synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
            enter_d  <= 1'b0;
        end else begin
            enter_s1 <= gf.enter;
            enter_s2 <= enter_s1;
            enter_d  <= enter_s2;
        end
    end

    // Game FSM with registered outputs, over-screen timer and spawn scheduler
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_START;
            score_q    <= '0;
            win_q      <= 1'b0;
            play_en_q  <= 1'b0;
            boss_en_q  <= 1'b0;
            end_en_q   <= 1'b0;
            game_rst_q <= 1'b0;
            spawn_q    <= 1'b0;
            spawn_cnt  <= '0;
            spawn_pend <= 1'b0;
            over_cnt   <= '0;
        end else begin
            st         <= nxt;
            score_q    <= nxt_score;
            win_q      <= nxt_win;
            play_en_q  <= nxt == ST_PLAY || nxt == ST_BOSS;
            boss_en_q  <= nxt == ST_BOSS;
            end_en_q   <= nxt == ST_OVER;
            game_rst_q <= start_game;
            spawn_q    <= spawn_now;
            over_cnt   <= (st == ST_OVER && nxt == ST_OVER) ? over_cnt + OW'(gf.frame_tick) : '0;
            if (st != ST_PLAY || nxt != ST_PLAY || spawn_now) begin
                spawn_cnt  <= '0;
                spawn_pend <= 1'b0;
            end else if (gf.frame_tick && spawn_cnt == SW'(SPAWN_FRAMES - 1)) begin
                spawn_pend <= 1'b1;
            end else if (gf.frame_tick) begin
                spawn_cnt <= spawn_cnt + SW'(1);
            end
        end
    end
endmodule
